// File: rtl/pmod_als_pkg.sv
// ---------------------------------------------------------------------------
// pmod_als_pkg
// Shared types and constants for the PmodALS (ADC081S021 frame format)
// responder.
//   state_t      : responder FSM states
//   *_DEF        : default frame geometry used by the responder parameters
//   build_frame  : places a light sample into the serial frame word
// ---------------------------------------------------------------------------
package pmod_als_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int LEAD_ZEROS_DEF = 3;
  localparam int FRAME_BITS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Frame word = {LEAD_ZEROS zeros, sample, zero pad}, MSB first on the wire.
  function automatic logic [FRAME_BITS_DEF-1:0] build_frame(
    input logic [DATA_W_DEF-1:0] sample
  );
    logic [FRAME_BITS_DEF-1:0] word;
    word = {FRAME_BITS_DEF{1'b0}};
    word[FRAME_BITS_DEF-1-LEAD_ZEROS_DEF -: DATA_W_DEF] = sample;
    return word;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Brings an asynchronous SPI line into the clk domain through SYNC_STAGES
// flops and produces registered one-cycle rise/fall pulses. A change on din
// shows up on rise/fall SYNC_STAGES+1 clocks later.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous reset, active-high
//   din   in  asynchronous line (cs or sck)
//   rise  out one-cycle pulse on a synchronized 0->1 transition
//   fall  out one-cycle pulse on a synchronized 1->0 transition
// IDLE_LEVEL is the reset value of the chain, so leaving reset with the line
// at its idle level produces no edge.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   dly_r;
  logic                   rise_r;
  logic                   fall_r;

  // Synchronizer chain, delayed copy of the last stage and edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{IDLE_LEVEL}};
      dly_r  <= IDLE_LEVEL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      dly_r  <= sync_r[SYNC_STAGES-1];
      rise_r <= sync_r[SYNC_STAGES-1] & ~dly_r;
      fall_r <= ~sync_r[SYNC_STAGES-1] & dly_r;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/pmod_als_responder.sv
// ---------------------------------------------------------------------------
// pmod_als_responder
// SPI responder emulating the PmodALS light sensor. On chip-select fall it
// captures a light sample, then shifts the frame {zeros, sample, pad} out on
// MISO, changing MISO only on SCK falling edges so it is stable at SCK rise.
// Ports:
//   clk_100Mhz_pi  in  system clock
//   rst_pi         in  synchronous reset, active-high
//   cs_pi          in  chip select, active-low, asynchronous
//   sck_pi         in  serial clock, idle low, asynchronous
//   sample_pi      in  DATA_W light value to report
//   miso_po        out serial data to master
//   busy_po        out high while a frame is in progress
//   frame_done_po  out one-cycle pulse after a complete frame and cs rise
//   frame_cnt_po   out 16-bit count of completed frames (wraps)
// Build option PMODALS_RAMP_EN: sample_pi is ignored and an internal
// counter, advanced at every completed frame, supplies the sample.
// ---------------------------------------------------------------------------
module pmod_als_responder
  import pmod_als_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LEAD_ZEROS  = LEAD_ZEROS_DEF,
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_100Mhz_pi,
  input  logic              rst_pi,
  input  logic              cs_pi,
  input  logic              sck_pi,
  input  logic [DATA_W-1:0] sample_pi,
  output logic              miso_po,
  output logic              busy_po,
  output logic              frame_done_po,
  output logic [15:0]       frame_cnt_po
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  logic cs_rise_s;
  logic cs_fall_s;
  logic sck_rise_s;
  logic sck_fall_s;

  state_t                  state_r;
  state_t                  state_s;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [CNT_W-1:0]        bit_cnt_s;
  logic [FRAME_BITS-1:0]   shift_r;
  logic [FRAME_BITS-1:0]   shift_s;
  logic [FRAME_BITS-1:0]   frame_s;
  logic                    miso_r;
  logic                    miso_s;
  logic                    busy_r;
  logic                    busy_s;
  logic                    done_r;
  logic                    done_s;
  logic [15:0]             frame_cnt_r;
  logic [15:0]             frame_cnt_s;
  logic [DATA_W-1:0]       sample_s;

  // cs idles high, so its chain resets high to avoid a false fall.
  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_LEVEL  (1'b1)
  ) u_cs_edge (
    .clk  (clk_100Mhz_pi),
    .rst  (rst_pi),
    .din  (cs_pi),
    .rise (cs_rise_s),
    .fall (cs_fall_s)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_LEVEL  (1'b0)
  ) u_sck_edge (
    .clk  (clk_100Mhz_pi),
    .rst  (rst_pi),
    .din  (sck_pi),
    .rise (sck_rise_s),
    .fall (sck_fall_s)
  );

`ifdef PMODALS_RAMP_EN
  logic [DATA_W-1:0] ramp_r;

  // Ramp sample source: advances once per completed frame.
  always_ff @(posedge clk_100Mhz_pi) begin
    if (rst_pi) begin
      ramp_r <= {DATA_W{1'b0}};
    end else if (done_s) begin
      ramp_r <= ramp_r + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      ramp_r <= ramp_r;
    end
  end

  assign sample_s = ramp_r;
`else
  assign sample_s = sample_pi;
`endif

  assign frame_s = build_frame(sample_s);

  // State and output registers.
  always_ff @(posedge clk_100Mhz_pi) begin
    if (rst_pi) begin
      state_r     <= IDLE;
      bit_cnt_r   <= {CNT_W{1'b0}};
      shift_r     <= {FRAME_BITS{1'b0}};
      miso_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      frame_cnt_r <= 16'h0000;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      miso_r      <= miso_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      frame_cnt_r <= frame_cnt_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    miso_s      = miso_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    frame_cnt_s = frame_cnt_r;

    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          shift_s   = frame_s;
          bit_cnt_s = {CNT_W{1'b0}};
          miso_s    = frame_s[FRAME_BITS-1];
          busy_s    = 1'b1;
          state_s   = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end

      SHIFT: begin
        if (cs_rise_s) begin
          // Abort: no completion pulse, count unchanged.
          bit_cnt_s = {CNT_W{1'b0}};
          miso_s    = 1'b0;
          busy_s    = 1'b0;
          state_s   = IDLE;
        end else if (cs_fall_s) begin
          shift_s   = frame_s;
          bit_cnt_s = {CNT_W{1'b0}};
          miso_s    = frame_s[FRAME_BITS-1];
          busy_s    = 1'b1;
          state_s   = SHIFT;
        end else if (sck_fall_s) begin
          shift_s = {shift_r[FRAME_BITS-2:0], 1'b0};
          miso_s  = shift_r[FRAME_BITS-2];
        end else if (sck_rise_s) begin
          if (bit_cnt_r == CNT_W'(FRAME_BITS - 1)) begin
            bit_cnt_s = CNT_W'(FRAME_BITS);
            miso_s    = 1'b0;
            state_s   = DONE;
          end else begin
            bit_cnt_s = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = SHIFT;
        end
      end

      DONE: begin
        miso_s = 1'b0;
        if (cs_rise_s) begin
          done_s      = 1'b1;
          frame_cnt_s = frame_cnt_r + 16'h0001;
          bit_cnt_s   = {CNT_W{1'b0}};
          busy_s      = 1'b0;
          state_s     = IDLE;
        end else if (cs_fall_s) begin
          // Missed cs rise: restart without a completion pulse.
          shift_s   = frame_s;
          bit_cnt_s = {CNT_W{1'b0}};
          miso_s    = frame_s[FRAME_BITS-1];
          busy_s    = 1'b1;
          state_s   = SHIFT;
        end else begin
          state_s = DONE;
        end
      end

      default: begin
        bit_cnt_s = {CNT_W{1'b0}};
        miso_s    = 1'b0;
        busy_s    = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  assign miso_po       = miso_r;
  assign busy_po       = busy_r;
  assign frame_done_po = done_r;
  assign frame_cnt_po  = frame_cnt_r;

endmodule

// File: tb/tb_pmod_als_responder.sv
// ---------------------------------------------------------------------------
// tb_pmod_als_responder
// Drives SPI frames into pmod_als_responder and compares the received words,
// busy/miso levels, completion pulses and frame count with a behavioural
// model of the sensor frame format.
// ---------------------------------------------------------------------------
module tb_pmod_als_responder;

  localparam int DATA_W     = 8;
  localparam int LEAD_ZEROS = 3;
  localparam int FRAME_BITS = 16;
  localparam int PAD_BITS   = FRAME_BITS - LEAD_ZEROS - DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cs  = 1'b1;
  logic              sck = 1'b0;
  logic [DATA_W-1:0] sample = 8'h00;
  logic              miso;
  logic              busy;
  logic              frame_done;
  logic [15:0]       frame_cnt;

  int tests  = 0;
  int failed = 0;
  int done_pulses = 0;

  // model state
  int model_cnt  = 0;
  int model_ramp = 0;

  pmod_als_responder dut (
    .clk_100Mhz_pi (clk),
    .rst_pi        (rst),
    .cs_pi         (cs),
    .sck_pi        (sck),
    .sample_pi     (sample),
    .miso_po       (miso),
    .busy_po       (busy),
    .frame_done_po (frame_done),
    .frame_cnt_po  (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done === 1'b1) done_pulses <= done_pulses + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sample the responder actually reports for a frame whose cs falls now.
  function automatic int model_sample(input logic [DATA_W-1:0] s);
`ifdef PMODALS_RAMP_EN
    return model_ramp;
`else
    return int'(s);
`endif
  endfunction

  // Word the master should see: sample placed after the lead zeros.
  function automatic logic [31:0] model_word(input int s);
    return 32'((s % 256) * (2 ** PAD_BITS));
  endfunction

  // Master: drop cs, give nedges SCK pulses, read miso at each rising edge.
  task automatic xfer(input int nedges, input int half, input int chg_at,
                      input logic [DATA_W-1:0] chg_val, output logic [31:0] rx);
    rx = 32'h0;
    cs = 1'b0;
    wait_clks(10);
    for (int i = 0; i < nedges; i++) begin
      if (i == chg_at) sample = chg_val;
      sck = 1'b1;
      rx  = {rx[30:0], miso};
      wait_clks(half);
      sck = 1'b0;
      wait_clks(half);
    end
  endtask

  task automatic release_cs();
    cs = 1'b1;
    wait_clks(12);
  endtask

  // One complete frame with full checking against the model.
  task automatic full_frame(input string tag, input logic [DATA_W-1:0] s, input int half,
                            input int nedges, input int chg_at, input logic [DATA_W-1:0] chg_val);
    logic [31:0] rx;
    int          pulses0;
    int          exp_s;
    sample  = s;
    exp_s   = model_sample(s);
    pulses0 = done_pulses;
    xfer(nedges, half, chg_at, chg_val, rx);
    check({tag, "_word"}, 32'(rx >> (nedges - FRAME_BITS)) & 32'h0000_FFFF, model_word(exp_s));
    if (nedges > FRAME_BITS)
      check({tag, "_tail"}, rx & ((32'h1 << (nedges - FRAME_BITS)) - 32'h1), 32'h0);
    check({tag, "_busy_in"}, 32'(busy), 32'h1);
    release_cs();
    model_cnt  = (model_cnt + 1) % 65536;
    model_ramp = (model_ramp + 1) % 256;
    check({tag, "_busy_out"}, 32'(busy), 32'h0);
    check({tag, "_miso_out"}, 32'(miso), 32'h0);
    check({tag, "_pulses"}, 32'(done_pulses - pulses0), 32'h1);
    check({tag, "_cnt"}, 32'(frame_cnt), 32'(model_cnt));
  endtask

  initial begin
    logic [31:0] rx;
    int          pulses0;

    // reset state
    wait_clks(4);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(frame_done), 32'h0);
    check("rst_cnt",  32'(frame_cnt), 32'h0);
    rst = 1'b0;
    wait_clks(6);
    check("idle_busy", 32'(busy), 32'h0);

    // directed frames
    full_frame("a5", 8'hA5, 50, 16, -1, 8'h00);
    full_frame("ff_chg", 8'hFF, 20, 16, 6, 8'h00);
    full_frame("zero", 8'h00, 20, 16, -1, 8'h00);

    // abort after 7 SCK
    pulses0 = done_pulses;
    sample  = 8'h5A;
    xfer(7, 10, -1, 8'h00, rx);
    check("abort_busy_in", 32'(busy), 32'h1);
    release_cs();
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_miso", 32'(miso), 32'h0);
    check("abort_pulses", 32'(done_pulses - pulses0), 32'h0);
    check("abort_cnt", 32'(frame_cnt), 32'(model_cnt));
    full_frame("post_abort", 8'h96, 10, 16, -1, 8'h00);

    // over-long frame: 20 SCK
    full_frame("long20", 8'h3C, 8, 20, -1, 8'h00);

    // SCK while cs high is ignored
    for (int i = 0; i < 5; i++) begin
      sck = 1'b1; wait_clks(8); sck = 1'b0; wait_clks(8);
    end
    check("sck_cs_high_busy", 32'(busy), 32'h0);
    check("sck_cs_high_miso", 32'(miso), 32'h0);

    // reset during bit 5
    sample = 8'hC3;
    xfer(5, 10, -1, 8'h00, rx);
    rst = 1'b1;
    wait_clks(1);
    check("midrst_miso", 32'(miso), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_cnt",  32'(frame_cnt), 32'h0);
    rst = 1'b0;
    cs  = 1'b1;
    wait_clks(12);
    model_cnt  = 0;
    model_ramp = 0;
    check("midrst_cnt_after", 32'(frame_cnt), 32'h0);
    full_frame("post_rst", 8'h81, 12, 16, -1, 8'h00);

    // randomized frames
    for (int i = 0; i < 6; i++) begin
      full_frame("rand", 8'($urandom_range(0, 255)), int'($urandom_range(6, 40)),
                 16, int'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #5ms;
    $display("FAIL timeout simulation did not complete");
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "timeout");
  end

endmodule
